// File: rtl/vmul_req_arbiter_ctrl.sv
// Round-robin front end sharing one vector-multiplier datapath.
// Optional perf counters: define VMUL_ARB_PERF_CNT_EN.
module vmul_req_arbiter_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [2*NUM_REQ-1:0]      req_opcode,
  input  logic [2*NUM_REQ-1:0]      req_precision,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      dp_start,
  output logic [1:0]                dp_opcode,
  output logic [1:0]                dp_precision,
  output logic [DATA_W-1:0]         dp_a,
  output logic [DATA_W-1:0]         dp_b,
  input  logic [DATA_W-1:0]         dp_result,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err
`ifdef VMUL_ARB_PERF_CNT_EN
  ,
  output logic [32*NUM_REQ-1:0]     perf_grant_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  localparam int ID_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LATENCY - 1);
  localparam logic [ID_W-1:0] RR_INIT =
    ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  rr_last;
  logic [ID_W-1:0]  id;
  logic [ID_W-1:0]  grant_id;
  logic [CNT_W-1:0] cnt;
  logic             grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]       sel_op;
  logic [1:0]       sel_prec;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic             sel_illegal;

  function automatic int rr_idx(
    input int base,
    input int k
  );
    return (base + k) % NUM_REQ;
  endfunction

  // cyclic priority search starting after rr_last
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (state == IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_any &&
            req_valid[rr_idx(int'(rr_last), k)]) begin
          grant_any = 1'b1;
          grant[rr_idx(int'(rr_last), k)] = 1'b1;
          grant_id = ID_W'(rr_idx(int'(rr_last), k));
        end
      end
    end
  end

  assign req_ready = grant;

  // request fields of the granted requester
  always_comb begin
    sel_op   = req_opcode[2*int'(grant_id) +: 2];
    sel_prec = req_precision[2*int'(grant_id) +: 2];
    sel_a    = req_a[DATA_W*int'(grant_id) +: DATA_W];
    sel_b    = req_b[DATA_W*int'(grant_id) +: DATA_W];
    sel_illegal = (sel_prec == 2'b11);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = sel_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready[id]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // capture, latency count and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last      <= RR_INIT;
      id           <= '0;
      cnt          <= '0;
      dp_opcode    <= '0;
      dp_precision <= '0;
      dp_a         <= '0;
      dp_b         <= '0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            id           <= grant_id;
            rr_last      <= grant_id;
            dp_opcode    <= sel_op;
            dp_precision <= sel_prec;
            dp_a         <= sel_a;
            dp_b         <= sel_b;
            cnt          <= CNT_INIT;
            resp_data    <= '0;
            resp_err     <= sel_illegal;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            resp_data <= dp_result;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready[id]) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign dp_start = (state == EXEC) &&
                    (cnt == CNT_INIT);

  // response valid routed to the owner only
  always_comb begin
    resp_valid = '0;
    if (state == RESP) begin
      resp_valid[id] = 1'b1;
    end
  end

`ifdef VMUL_ARB_PERF_CNT_EN
  // grant and stall counters, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant_any) begin
        perf_grant_cnt[32*int'(grant_id) +: 32] <=
          perf_grant_cnt[32*int'(grant_id) +: 32]
          + 32'd1;
      end
      if ((|req_valid) && !(|req_ready)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vmul_req_arbiter_ctrl.sv
// Bench for vmul_req_arbiter_ctrl with a latency-true
// datapath model and a round-robin reference model.
module tb_vmul_req_arbiter_ctrl;

  localparam int N   = 2;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_opcode;
  logic [2*N-1:0] req_precision;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic           dp_start;
  logic [1:0]     dp_opcode;
  logic [1:0]     dp_precision;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_result;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [W-1:0]   resp_data;
  logic           resp_err;
`ifdef VMUL_ARB_PERF_CNT_EN
  logic [32*N-1:0] perf_grant_cnt;
  logic [31:0]     perf_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  vmul_req_arbiter_ctrl #(
    .NUM_REQ(N), .DATA_W(W), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_opcode(req_opcode),
    .req_precision(req_precision),
    .req_a(req_a),
    .req_b(req_b),
    .dp_start(dp_start),
    .dp_opcode(dp_opcode),
    .dp_precision(dp_precision),
    .dp_a(dp_a),
    .dp_b(dp_b),
    .dp_result(dp_result),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_err(resp_err)
`ifdef VMUL_ARB_PERF_CNT_EN
    ,
    .perf_grant_cnt(perf_grant_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // datapath: product valid only in the LAT-th EXEC cycle
  logic [3:0] ex_k;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_k <= '0;
    else if (dp_start) ex_k <= 4'd2;
    else if (ex_k != 0 && ex_k < 15) ex_k <= ex_k + 4'd1;
  end
  int phase;
  assign phase = dp_start ? 1 : int'(ex_k);
  assign dp_result = (phase == LAT) ? dp_a * dp_b
                                    : 32'hDEAD_BEEF;

  function automatic int rr_pick(
    input int last,
    input logic [N-1:0] v
  );
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_req(
    input int i, input logic [1:0] op,
    input logic [1:0] pr, input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    req_opcode[2*i +: 2]    = op;
    req_precision[2*i +: 2] = pr;
    req_a[W*i +: W]         = a;
    req_b[W*i +: W]         = b;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    req_opcode = '0;
    req_precision = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, dp_start, dp_opcode, dp_precision,
         dp_a, dp_b, resp_valid, resp_data,
         resp_err} !== '0) begin
      errors++;
      $display("FAIL reset_in got nonzero outputs");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, dp_start, dp_opcode, dp_precision,
         dp_a, dp_b, resp_valid, resp_data,
         resp_err} !== '0) begin
      errors++;
      $display("FAIL reset_out got nonzero outputs");
    end
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rdy01 got %b want 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rdy10 got %b want 10", req_ready);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rdy11 got %b want 01", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    do_reset();
    set_req(0, 2'b00, 2'b10, 32'd7, 32'd6);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_rdy got %b want 01", req_ready);
    end
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (dp_start !== (c == 1)) begin
        errors++;
        $display("FAIL single_start c%0d got %b",
                 c, dp_start);
      end
      if (c <= LAT) begin
        checks++;
        if ({dp_opcode, dp_precision, dp_a, dp_b} !==
            {2'b00, 2'b10, 32'd7, 32'd6}) begin
          errors++;
          $display("FAIL single_dp c%0d got a=%0d b=%0d",
                   c, dp_a, dp_b);
        end
      end
      checks++;
      if (resp_valid !== ((c == LAT + 1) ? 2'b01
                                         : 2'b00)) begin
        errors++;
        $display("FAIL single_rv c%0d got %b",
                 c, resp_valid);
      end
    end
    checks++;
    if (resp_data !== 32'd42 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_data got %0d want 42",
               resp_data);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if ({resp_valid, resp_data, resp_err} !== '0) begin
      errors++;
      $display("FAIL single_clr got rv=%b d=%0d",
               resp_valid, resp_data);
    end
  endtask

  task automatic test_contention;
    int last;
    int exp;
    int cyc;
    logic [W-1:0] ea[N];
    logic [W-1:0] eb[N];
    do_reset();
    last = N - 1;
    for (int i = 0; i < N; i++) begin
      ea[i] = $urandom;
      eb[i] = $urandom;
      set_req(i, 2'b00, 2'b10, ea[i], eb[i]);
    end
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      resp_ready = '0;
      #1;
      exp = rr_pick(last, req_valid);
      last = exp;
      checks++;
      if (exp != g % 2 ||
          req_ready !== (2'b01 << exp)) begin
        errors++;
        $display("FAIL cont_grant%0d got %b want %0d",
                 g, req_ready, g % 2);
      end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (resp_valid === '0 && cyc < 12);
      checks++;
      if (resp_valid !== (2'b01 << exp) ||
          cyc != LAT + 1 ||
          resp_data !== ea[exp] * eb[exp]) begin
        errors++;
        $display("FAIL cont_resp%0d rv=%b cyc=%0d d=%h",
                 g, resp_valid, cyc, resp_data);
      end
      resp_ready = 2'b11;
      @(negedge clk);
      ea[exp] = $urandom;
      eb[exp] = $urandom;
      set_req(exp, 2'b00, 2'b10, ea[exp], eb[exp]);
    end
    req_valid = '0;
    resp_ready = '0;
`ifdef VMUL_ARB_PERF_CNT_EN
    checks++;
    if (perf_grant_cnt !== {32'd2, 32'd2}) begin
      errors++;
      $display("FAIL perf_grant got %h want 2,2",
               perf_grant_cnt);
    end
`endif
  endtask

  task automatic test_illegal;
    do_reset();
    set_req(1, 2'b01, 2'b11, 32'd9, 32'd9);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL ill_rdy got %b want 10", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (resp_valid !== 2'b10 || resp_err !== 1'b1 ||
        resp_data !== '0 || dp_start !== 1'b0) begin
      errors++;
      $display("FAIL ill_resp rv=%b err=%b d=%0d st=%b",
               resp_valid, resp_err, resp_data, dp_start);
    end
    resp_ready = 2'b10;
    @(negedge clk);
    resp_ready = '0;
    checks++;
    if (resp_valid !== '0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL ill_clr rv=%b err=%b",
               resp_valid, resp_err);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    set_req(0, 2'b00, 2'b10, 32'd123, 32'd456);
    req_valid = 2'b01;
    repeat (LAT + 1) @(negedge clk);
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      resp_ready = 2'b10;
      #1;
      checks++;
      if (resp_valid !== 2'b01 ||
          resp_data !== 32'd56088 ||
          req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d rv=%b d=%0d rdy=%b",
                 c, resp_valid, resp_data, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 2'b01;
    @(negedge clk);
    resp_ready = '0;
    #1;
    checks++;
    if (resp_valid !== '0 || resp_data !== '0 ||
        req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release rv=%b d=%0d rdy=%b",
               resp_valid, resp_data, req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midop;
    int bad;
    do_reset();
    set_req(0, 2'b00, 2'b10, 32'd11, 32'd13);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, dp_start, dp_opcode, dp_precision,
         dp_a, dp_b, resp_valid, resp_data,
         resp_err} !== '0) begin
      errors++;
      $display("FAIL midop_rst got nonzero outputs");
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== '0 || dp_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midop_ghost got %0d want 0", bad);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midop_next got %b want 01",
               req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_random(input int nops);
    int last;
    int g;
    int cyc;
    int starts;
    int d;
    logic seen;
    logic ill;
    logic [1:0] eop;
    logic [1:0] epr;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] ed;
    logic [N-1:0] oh;
    do_reset();
    last = N - 1;
    for (int op = 0; op < nops; op++) begin
      resp_ready = '0;
      for (int i = 0; i < N; i++)
        set_req(i, 2'($urandom),
                ($urandom_range(0, 4) == 0) ? 2'b11
                  : 2'($urandom_range(0, 2)),
                $urandom, $urandom);
      req_valid = 2'($urandom_range(1, 3));
      #1;
      g = rr_pick(last, req_valid);
      last = g;
      oh = 2'b01 << g;
      eop = req_opcode[2*g +: 2];
      epr = req_precision[2*g +: 2];
      ea = req_a[W*g +: W];
      eb = req_b[W*g +: W];
      ill = (epr == 2'b11);
      ed = ill ? '0 : ea * eb;
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL rnd%0d_grant got %b want %b",
                 op, req_ready, oh);
      end
      cyc = 0;
      starts = 0;
      seen = 1'b0;
      while (!seen && cyc < 12) begin
        @(negedge clk);
        cyc++;
        req_valid = 2'($urandom_range(0, 3));
        #1;
        if (dp_start) starts++;
        checks++;
        if (req_ready !== '0) begin
          errors++;
          $display("FAIL rnd%0d_busy got %b want 00",
                   op, req_ready);
        end
        if (!ill && cyc <= LAT) begin
          checks++;
          if ({dp_opcode, dp_precision, dp_a, dp_b} !==
              {eop, epr, ea, eb}) begin
            errors++;
            $display("FAIL rnd%0d_dp got a=%h want %h",
                     op, dp_a, ea);
          end
        end
        if (resp_valid !== '0) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rnd%0d_timeout got none want %b",
                 op, oh);
      end else if (resp_valid !== oh ||
                   resp_err !== ill ||
                   resp_data !== ed ||
                   cyc != (ill ? 1 : LAT + 1) ||
                   starts != (ill ? 0 : 1)) begin
        errors++;
        $display("FAIL rnd%0d_resp rv=%b e=%b d=%h cyc=%0d st=%0d want %b %b %h",
                 op, resp_valid, resp_err, resp_data,
                 cyc, starts, oh, ill, ed);
      end
      d = $urandom_range(0, 3);
      repeat (d) begin
        resp_ready = 2'($urandom) & ~oh;
        @(negedge clk);
        #1;
        checks++;
        if (resp_valid !== oh || resp_data !== ed ||
            resp_err !== ill) begin
          errors++;
          $display("FAIL rnd%0d_hold rv=%b d=%h",
                   op, resp_valid, resp_data);
        end
      end
      resp_ready = oh | 2'($urandom);
      @(negedge clk);
      checks++;
      if ({resp_valid, resp_data, resp_err} !== '0) begin
        errors++;
        $display("FAIL rnd%0d_clr rv=%b d=%h",
                 op, resp_valid, resp_data);
      end
    end
    req_valid = '0;
    resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_backpressure();
    test_reset_midop();
    test_random(40);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
